// File: rtl/ccsds_turbo_enc_rsc_pkg.sv
// Shared trellis constants for the CCSDS turbo code (encoder and decoder side).
// Polynomials are stored with bit i = coefficient of D^i.
package ccsds_turbo_enc_rsc_pkg;

   localparam int cSTATE_NUM = 16;
   localparam int cMEM       = $clog2(cSTATE_NUM);

   localparam logic [cMEM:0] cG0 = 5'b11001;  // 1+D^3+D^4 (feedback)
   localparam logic [cMEM:0] cG1 = 5'b11011;  // 1+D+D^3+D^4
   localparam logic [cMEM:0] cG2 = 5'b10101;  // 1+D^2+D^4
   localparam logic [cMEM:0] cG3 = 5'b11111;  // 1+D+D^2+D^3+D^4

   localparam int cTAIL_NUM = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_TAIL
   } state_e;

   // word = {p3,p2,p1,sys}
   typedef struct packed {
      logic [3:0]      word;
      logic [cMEM-1:0] ns;
   } step_t;

endpackage

// File: rtl/ccsds_turbo_enc_rsc_if.sv
// Bit-stream in / coded-word out handshake of one RSC constituent encoder.
interface ccsds_turbo_enc_rsc_if;

   logic       iclkena;
   logic       ival;
   logic       isop;
   logic       ieop;
   logic       idat;
   logic       ordy;
   logic       oval;
   logic       osop;
   logic       oeop;
   logic       otail;
   logic [3:0] odat;

   modport master (
      output iclkena, ival, isop, ieop, idat,
      input  ordy, oval, osop, oeop, otail, odat
   );

   modport slave (
      input  iclkena, ival, isop, ieop, idat,
      output ordy, oval, osop, oeop, otail, odat
   );

endinterface

// File: rtl/ccsds_turbo_enc_rsc.sv
// CCSDS 16-state RSC constituent encoder: one bit per accepted cycle, registered
// {p3,p2,p1,sys} output, followed by trellis termination back to state 0.
module ccsds_turbo_enc_rsc
   import ccsds_turbo_enc_rsc_pkg::*;
#(
   parameter int pTAIL_NUM = cTAIL_NUM
) (
   input  logic                  iclk,
   input  logic                  ireset,
   ccsds_turbo_enc_rsc_if.slave  bus
);

   localparam int CW = (pTAIL_NUM > 1) ? $clog2(pTAIL_NUM) : 1;

   // s[0] holds the newest bit, s[cMEM-1] the oldest (D^4) tap.
   function automatic step_t step(input logic u, input logic [cMEM-1:0] s);
      logic  a;
      step_t r;
      a      = u ^ (^(cG0[cMEM:1] & s));
      r.word = {a ^ (^(cG3[cMEM:1] & s)),
                a ^ (^(cG2[cMEM:1] & s)),
                a ^ (^(cG1[cMEM:1] & s)),
                u};
      r.ns   = {s[cMEM-2:0], a};
      return r;
   endfunction

   state_e          state_q, state_d;
   logic [cMEM-1:0] s_q, s_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            oval_q, oval_d;
   logic            osop_q, osop_d;
   logic            oeop_q, oeop_d;
   logic            otail_q, otail_d;
   logic [3:0]      odat_q, odat_d;

   logic            ordy;
   logic            acc;
   logic            u_in;
   logic [cMEM-1:0] s_in;
   step_t           st;

   assign ordy = (state_q != ST_TAIL);
   assign acc  = bus.iclkena & bus.ival & ordy;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      oval_d  = oval_q;
      osop_d  = osop_q;
      oeop_d  = oeop_q;
      otail_d = otail_q;
      odat_d  = odat_q;

      // A frame start always encodes from the zero state; tail feeds back a=0.
      s_in = s_q;
      u_in = bus.idat;
      if (state_q == ST_IDLE || bus.isop) s_in = '0;
      if (state_q == ST_TAIL) begin
         s_in = s_q;
         u_in = ^(cG0[cMEM:1] & s_q);
      end
      st = step(u_in, s_in);

      if (bus.iclkena) begin
         oval_d  = 1'b0;
         osop_d  = 1'b0;
         oeop_d  = 1'b0;
         otail_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (acc && bus.isop) begin
                  s_d     = st.ns;
                  odat_d  = st.word;
                  oval_d  = 1'b1;
                  osop_d  = 1'b1;
                  state_d = bus.ieop ? ST_TAIL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (acc) begin
                  s_d    = st.ns;
                  odat_d = st.word;
                  oval_d = 1'b1;
                  osop_d = bus.isop;
                  if (bus.ieop) state_d = ST_TAIL;
               end
            end
            ST_TAIL: begin
               s_d     = st.ns;
               odat_d  = st.word;
               oval_d  = 1'b1;
               otail_d = 1'b1;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(pTAIL_NUM - 1)) begin
                  oeop_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         cnt_q   <= '0;
         oval_q  <= 1'b0;
         osop_q  <= 1'b0;
         oeop_q  <= 1'b0;
         otail_q <= 1'b0;
         odat_q  <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         oval_q  <= oval_d;
         osop_q  <= osop_d;
         oeop_q  <= oeop_d;
         otail_q <= otail_d;
         odat_q  <= odat_d;
      end
   end

   assign bus.ordy  = ordy;
   assign bus.oval  = oval_q;
   assign bus.osop  = osop_q;
   assign bus.oeop  = oeop_q;
   assign bus.otail = otail_q;
   assign bus.odat  = odat_q;

   // Termination must land the trellis back in state 0 with the last tail word.
   a_tail_zero: assert property (@(posedge iclk) disable iff (!ireset)
      (oval_q && oeop_q) |-> (s_q == '0));

endmodule

// File: tb/tb_ccsds_turbo_enc_rsc.sv
// Directed bench for the CCSDS RSC constituent encoder with hand-derived code words.
module tb_ccsds_turbo_enc_rsc;

   logic iclk   = 1'b0;
   logic ireset = 1'b0;

   ccsds_turbo_enc_rsc_if bus();

   ccsds_turbo_enc_rsc dut (
      .iclk   (iclk),
      .ireset (ireset),
      .bus    (bus.slave)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      logic [3:0] d;
      logic       s;
      logic       e;
      logic       t;
   } wrd_t;

   wrd_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // Only words produced by an enabled edge are collected, so a frozen oval
   // is not counted twice.
   always @(posedge iclk) begin : mon
      logic en;
      en = bus.iclkena;
      #1;
      if (en && ireset && bus.oval)
         q.push_back('{d: bus.odat, s: bus.osop, e: bus.oeop, t: bus.otail});
   end

   task automatic send(input logic sop, input logic eop, input logic dat, input bit rnd);
      bit acc;
      int b;
      acc = 1'b0;
      b   = 0;
      while (!acc && b < 100) begin
         @(negedge iclk);
         bus.iclkena = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.ival    = 1'b1;
         bus.isop    = sop;
         bus.ieop    = eop;
         bus.idat    = dat;
         acc         = bus.iclkena && bus.ordy;
         @(posedge iclk);
         b++;
      end
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge iclk);
         bus.ival    = 1'b0;
         bus.isop    = 1'b0;
         bus.ieop    = 1'b0;
         bus.iclkena = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic wait_words(input string tag, input int n, input bit rnd);
      int b;
      b = 0;
      while (q.size() < n && b < 300) begin
         idle(1, rnd);
         b++;
      end
      idle(3, 1'b0);
      chk(tag, 64'(q.size()), 64'(n));
   endtask

   // First word lands in the most significant position.
   task automatic grab(input int n, output logic [63:0] d, output logic [15:0] s,
                       output logic [15:0] e, output logic [15:0] t);
      d = '0; s = '0; e = '0; t = '0;
      for (int i = 0; i < n; i++) begin
         wrd_t w;
         if (q.size() == 0) w = '{d: 4'h0, s: 1'b0, e: 1'b0, t: 1'b0};
         else w = q.pop_front();
         d = {d[59:0], w.d};
         s = {s[14:0], w.s};
         e = {e[14:0], w.e};
         t = {t[14:0], w.t};
      end
      q.delete();
   endtask

   initial begin
      logic [63:0] d;
      logic [15:0] s, e, t;
      int          lows;

      bus.iclkena = 1'b1;
      bus.ival    = 1'b0;
      bus.isop    = 1'b0;
      bus.ieop    = 1'b0;
      bus.idat    = 1'b0;

      repeat (2) @(negedge iclk);
      chk("rst_ordy",  64'(bus.ordy),  64'd1);
      chk("rst_oval",  64'(bus.oval),  64'd0);
      chk("rst_odat",  64'(bus.odat),  64'd0);
      chk("rst_osop",  64'(bus.osop),  64'd0);
      chk("rst_oeop",  64'(bus.oeop),  64'd0);
      chk("rst_otail", 64'(bus.otail), 64'd0);
      ireset = 1'b1;
      idle(2, 1'b0);

      // Valid without isop in IDLE is dropped.
      send(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);
      chk("idle_drop", 64'(q.size()), 64'd0);

      for (int i = 0; i < 8; i++) send(i == 0, i == 7, 1'b0, 1'b0);
      wait_words("zero_cnt", 12, 1'b0);
      grab(12, d, s, e, t);
      chk("zero_dat",  d, 64'h0);
      chk("zero_tail", 64'(t), 64'h00F);
      chk("zero_eop",  64'(e), 64'h001);
      chk("zero_sop",  64'(s), 64'h800);

      send(1'b1, 1'b1, 1'b1, 1'b0);
      wait_words("imp_cnt", 5, 1'b0);
      grab(5, d, s, e, t);
      chk("imp_dat",  d, 64'hFACBF);
      chk("imp_tail", 64'(t), 64'h0F);
      chk("imp_eop",  64'(e), 64'h01);
      chk("imp_sop",  64'(s), 64'h10);
      chk("hold_odat", 64'(bus.odat), 64'hF);
      chk("hold_oval", 64'(bus.oval), 64'd0);

      send(1'b1, 1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0, 1'b0);
      wait_words("two_cnt", 6, 1'b0);
      grab(6, d, s, e, t);
      chk("two_dat",  d, 64'hFACBF0);
      chk("two_tail", 64'(t), 64'h0F);
      chk("two_eop",  64'(e), 64'h01);

      // ival held high across the tail: 4 not-ready cycles, then a fresh frame.
      lows = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge iclk);
         bus.iclkena = 1'b1;
         bus.ival    = 1'b1;
         bus.isop    = 1'b1;
         bus.ieop    = 1'b1;
         bus.idat    = 1'b1;
         if (!bus.ordy) lows++;
      end
      wait_words("hs_cnt", 10, 1'b0);
      chk("hs_rdy_low", 64'(lows), 64'd4);
      grab(10, d, s, e, t);
      chk("hs_dat", d, 64'hFACBFFACBF);
      chk("hs_sop", 64'(s), 64'h210);
      chk("hs_eop", 64'(e), 64'h021);

      send(1'b1, 1'b1, 1'b1, 1'b1);
      wait_words("cke_cnt", 5, 1'b1);
      grab(5, d, s, e, t);
      chk("cke_dat", d, 64'hFACBF);
      chk("cke_eop", 64'(e), 64'h01);
      chk("cke_tail", 64'(t), 64'h0F);

      // Asynchronous reset during the second tail cycle.
      send(1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge iclk);
      @(posedge iclk);
      #2;
      bus.ival = 1'b0;
      ireset   = 1'b0;
      #1;
      chk("mid_words", 64'(q.size()), 64'd3);
      chk("mid_ordy",  64'(bus.ordy),  64'd1);
      chk("mid_oval",  64'(bus.oval),  64'd0);
      chk("mid_odat",  64'(bus.odat),  64'd0);
      chk("mid_otail", 64'(bus.otail), 64'd0);
      chk("mid_oeop",  64'(bus.oeop),  64'd0);
      q.delete();
      @(negedge iclk);
      ireset = 1'b1;
      idle(2, 1'b0);
      chk("mid_nopart", 64'(q.size()), 64'd0);
      send(1'b1, 1'b0, 1'b1, 1'b0);
      send(1'b0, 1'b1, 1'b0, 1'b0);
      wait_words("post_cnt", 6, 1'b0);
      grab(6, d, s, e, t);
      chk("post_dat", d, 64'hFACBF0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
